// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared definitions for the bus transfer controller.
//   op_e    : command opcodes (NOP / LOAD / STORE / MOVE)
//   unit_e  : bus module codes (R1 / R2 / R3 / Acc)
//   state_e : sequencer states (IDLE / EXEC / TURN)
//   cmd_t   : one queued command {op, src, dst}
//   cmd_dir : external pin direction a command needs (1 = unit drives the bus)
package bus_xfer_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_MOVE  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        U_R1  = 2'd0,
        U_R2  = 2'd1,
        U_R3  = 2'd2,
        U_ACC = 2'd3
    } unit_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    typedef struct packed {
        op_e   op;
        unit_e src;
        unit_e dst;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // A MOVE onto itself is executed as a NOP, so it does not drive the bus.
    function automatic logic cmd_dir(input cmd_t c);
        return (c.op == OP_STORE) || ((c.op == OP_MOVE) && (c.src != c.dst));
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_cmd_fifo.sv
// Command FIFO, DEPTH entries of W bits, first-word fall-through head.
//   clk, rst_n : clock, synchronous active-low reset
//   push, pop  : write / read requests; both honoured in one cycle, even when full
//   wr_data    : entry to write
//   rd_data    : current head entry (valid while !empty)
//   full,empty : occupancy flags
module bus_xfer_ctrl_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    // A push into a full FIFO is fine if the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequencer for the shared 8-bit bus between R1, R2, R3, Acc and the pins.
//   Clock, nReset       : clock, synchronous active-low reset
//   CmdValid/CmdReady   : command handshake (CmdReady = FIFO not full)
//   CmdOp/CmdSrc/CmdDst : queued command fields
//   Sel*/RnW*           : registered select / read-not-write per bus module
//   Busy                : FIFO non-empty or sequencer not idle
//   Done                : pulse in the EXEC cycle of each command
//   Err                 : pulse for MOVE with Src == Dst (executed as NOP)
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       CmdValid,
    output logic       CmdReady,
    input  logic [1:0] CmdOp,
    input  logic [1:0] CmdSrc,
    input  logic [1:0] CmdDst,
    output logic       Sel1,
    output logic       RnW1,
    output logic       Sel2,
    output logic       RnW2,
    output logic       Sel3,
    output logic       RnW3,
    output logic       SelA,
    output logic       RnWa,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    state_e     state_reg, state_next;
    cmd_t       cmd_reg;        // command popped last; held through TURN
    cmd_t       head;
    cmd_t       wr_cmd;
    cmd_t       exec_cmd;       // command the next cycle executes, if any
    logic       fifo_full, fifo_empty;
    logic       push, pop;
    logic       last_dir;
    logic       exec_go;
    logic [3:0] sel_reg, sel_next;
    logic [3:0] rnw_reg, rnw_next;
    logic       done_reg, done_next;
    logic       err_reg, err_next;
    logic       is_load, is_store, is_move;

    assign wr_cmd   = '{op: op_e'(CmdOp), src: unit_e'(CmdSrc), dst: unit_e'(CmdDst)};
    assign CmdReady = !fifo_full;
    assign push     = CmdValid && !fifo_full;
    assign pop      = (state_reg != ST_TURN) && !fifo_empty;
    // Direction of the previous EXEC; an IDLE cycle forgets it.
    assign last_dir = (state_reg == ST_EXEC) ? cmd_dir(cmd_reg) : 1'b0;

    bus_xfer_ctrl_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (nReset),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_cmd),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register and registered outputs.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_reg <= ST_IDLE;
            cmd_reg   <= '0;
            sel_reg   <= '0;
            rnw_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (pop) cmd_reg <= head;
            sel_reg   <= sel_next;
            rnw_reg   <= rnw_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_EXEC: begin
                if (fifo_empty)
                    state_next = ST_IDLE;
                else if (cmd_dir(head) == last_dir)
                    state_next = ST_EXEC;
                else
                    state_next = ST_TURN;
            end
            ST_TURN: state_next = ST_EXEC;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode for the coming cycle; TURN and IDLE leave everything low.
    always_comb begin
        exec_cmd  = (state_reg == ST_TURN) ? cmd_reg : head;
        exec_go   = (state_next == ST_EXEC);
        is_load   = exec_go && (exec_cmd.op == OP_LOAD);
        is_store  = exec_go && (exec_cmd.op == OP_STORE);
        is_move   = exec_go && (exec_cmd.op == OP_MOVE) && (exec_cmd.src != exec_cmd.dst);
        done_next = exec_go;
        err_next  = exec_go && (exec_cmd.op == OP_MOVE) && (exec_cmd.src == exec_cmd.dst);
    end

    // 1-of-4 decoder: only the source unit ever gets RnW=1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_unit
            assign sel_next[gi] = (is_load  && (exec_cmd.dst == unit_e'(gi))) ||
                                  (is_store && (exec_cmd.src == unit_e'(gi))) ||
                                  (is_move  && ((exec_cmd.src == unit_e'(gi)) ||
                                                (exec_cmd.dst == unit_e'(gi))));
            assign rnw_next[gi] = (is_store || is_move) && (exec_cmd.src == unit_e'(gi));
        end
    endgenerate

    assign Sel1 = sel_reg[0];
    assign RnW1 = rnw_reg[0];
    assign Sel2 = sel_reg[1];
    assign RnW2 = rnw_reg[1];
    assign Sel3 = sel_reg[2];
    assign RnW3 = rnw_reg[2];
    assign SelA = sel_reg[3];
    assign RnWa = rnw_reg[3];
    assign Done = done_reg;
    assign Err  = err_reg;
    assign Busy = !fifo_empty || (state_reg != ST_IDLE);

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Randomized bench for bus_xfer_ctrl. The reference model schedules every
// accepted command in time (pop cycle, optional turnaround, exec cycle) from
// its push edge and the previous command's schedule, then derives the
// expected outputs of each cycle from those schedules.
module tb_bus_xfer_ctrl;

    localparam int DEPTH = 4;
    localparam int NCYC  = 2500;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       CmdValid;
    logic       CmdReady;
    logic [1:0] CmdOp, CmdSrc, CmdDst;
    logic       Sel1, RnW1, Sel2, RnW2, Sel3, RnW3, SelA, RnWa;
    logic       Busy, Done, Err;

    always #5 Clock = ~Clock;

    bus_xfer_ctrl #(.DEPTH(DEPTH)) dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .CmdValid (CmdValid),
        .CmdReady (CmdReady),
        .CmdOp    (CmdOp),
        .CmdSrc   (CmdSrc),
        .CmdDst   (CmdDst),
        .Sel1     (Sel1),
        .RnW1     (RnW1),
        .Sel2     (Sel2),
        .RnW2     (RnW2),
        .Sel3     (Sel3),
        .RnW3     (RnW3),
        .SelA     (SelA),
        .RnWa     (RnWa),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: accepted commands with their scheduled cycles.
    logic [5:0] q_cmd [$];
    int         q_push[$];
    int         q_pop [$];
    int         q_exec[$];
    int         last_exec;
    logic       last_d;

    function automatic logic cmd_d(input logic [5:0] c);
        logic [1:0] op, src, dst;
        op = c[5:4]; src = c[3:2]; dst = c[1:0];
        return (op == 2'b10) || (op == 2'b11 && src != dst);
    endfunction

    // {sel[3:0], rnw[3:0], done, err} during the EXEC cycle of command c
    function automatic logic [9:0] exec_bus(input logic [5:0] c);
        logic [1:0] op, src, dst;
        logic [3:0] sel, rnw;
        logic       err;
        op = c[5:4]; src = c[3:2]; dst = c[1:0];
        sel = '0; rnw = '0; err = 1'b0;
        case (op)
            2'b01: sel[dst] = 1'b1;
            2'b10: begin sel[src] = 1'b1; rnw[src] = 1'b1; end
            2'b11: begin
                if (src == dst) err = 1'b1;
                else begin
                    sel[src] = 1'b1; rnw[src] = 1'b1; sel[dst] = 1'b1;
                end
            end
            default: ;
        endcase
        return {sel, rnw, 1'b1, err};
    endfunction

    task automatic model_reset();
        q_cmd.delete(); q_push.delete(); q_pop.delete(); q_exec.delete();
        last_exec = -100;
        last_d    = 1'b0;
    endtask

    task automatic model_push(input int edge_n, input logic [5:0] c);
        int   p, e;
        logic ld, d;
        d  = cmd_d(c);
        // Popped at the push edge's cycle or during the previous EXEC, whichever is later.
        p  = (edge_n > last_exec) ? edge_n : last_exec;
        ld = (p == last_exec) ? last_d : 1'b0;
        e  = p + 1 + ((d != ld) ? 1 : 0);
        q_cmd.push_back(c); q_push.push_back(edge_n);
        q_pop.push_back(p); q_exec.push_back(e);
        last_exec = e;
        last_d    = d;
    endtask

    initial begin
        int          n;
        logic        ready_m, busy_m, exec_hit;
        int          occ;
        logic [9:0]  bus_m;
        logic [11:0] exp_vec, got_vec;
        int          exp_done, got_done, valid_pct;

        nReset = 1'b0; CmdValid = 1'b0; CmdOp = '0; CmdSrc = '0; CmdDst = '0;
        exp_done = 0; got_done = 0;
        model_reset();
        n = 0;
        @(posedge Clock);   // edge 0: reset sampled low

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge Clock);
            bus_m = '0; busy_m = 1'b0; occ = 0; exec_hit = 1'b0;
            for (int i = 0; i < q_cmd.size(); i++) begin
                if (q_exec[i] == n) begin
                    bus_m    = exec_bus(q_cmd[i]);
                    exec_hit = 1'b1;
                    $display("xfer cyc=%0d op=%0d src=%0d dst=%0d", n,
                             q_cmd[i][5:4], q_cmd[i][3:2], q_cmd[i][1:0]);
                end
                if (q_pop[i] < n && n <= q_exec[i]) busy_m = 1'b1;
                if (q_push[i] <= n && q_pop[i] >= n) occ++;
            end
            if (occ > 0) busy_m = 1'b1;
            ready_m = (occ < DEPTH);
            if (exec_hit) exp_done++;
            if (Done === 1'b1) got_done++;

            exp_vec = {bus_m, busy_m, ready_m};
            got_vec = {SelA, Sel3, Sel2, Sel1, RnWa, RnW3, RnW2, RnW1, Done, Err, Busy, CmdReady};
            check_val($sformatf("cyc%0d", n), 32'(got_vec), 32'(exp_vec));

            while (q_exec.size() > 0 && q_exec[0] <= n) begin
                void'(q_cmd.pop_front()); void'(q_push.pop_front());
                void'(q_pop.pop_front()); void'(q_exec.pop_front());
            end

            // Stimulus for the next edge: bursts and sparse phases, periodic 2-edge resets.
            valid_pct = ((n / 100) % 2 == 0) ? 90 : 30;
            nReset    = !((n % 400 == 250) || (n % 400 == 251));
            CmdValid  = ($urandom_range(0, 99) < valid_pct);
            case ($urandom_range(0, 9))
                0:       CmdOp = 2'b00;
                1, 2, 3: CmdOp = 2'b01;
                4, 5, 6: CmdOp = 2'b10;
                default: CmdOp = 2'b11;
            endcase
            CmdSrc = 2'($urandom_range(0, 3));
            CmdDst = 2'($urandom_range(0, 3));

            @(posedge Clock);
            n++;
            if (!nReset)
                model_reset();
            else if (CmdValid && ready_m)
                model_push(n, {CmdOp, CmdSrc, CmdDst});
        end

        check_val("done_total", 32'(got_done), 32'(exp_done));
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
